ccff_loader: RTL and testbench

Configuration-chain loader that sits directly upstream of the fabric's configuration-flip-flop chain. It accepts the bitstream as a byte stream over a valid/ready handshake and serializes it onto `ccff_head`. It produces a clock-enable that the top level uses to gate the chain's programming clock, so the chain only advances when a valid bit is present. After the last bit it checks the bit returned on `ccff_tail` and reports completion and error status.

---
 rtl/fpga_cfg_pkg.sv | 10 +
 rtl/ccff_loader_if.sv | 10 +
 rtl/ccff_byte_serializer.sv | 64 ++++++
 rtl/ccff_loader.sv | 78 +++++++
 tb/tb_ccff_loader.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/fpga_cfg_pkg.sv
// fpga_cfg_pkg: shared state encoding, bus width and sizing helper for the configuration loader
package fpga_cfg_pkg;
    localparam int CFG_DATA_W = 8;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_CHECK, ST_DONE} cfg_state_t;

    function automatic int cfg_num_bytes(input int chain_len);
        return (chain_len + CFG_DATA_W - 1) / CFG_DATA_W;
    endfunction
endpackage

// File: rtl/ccff_loader_if.sv
// ccff_loader_if: valid/ready byte stream carrying the bitstream into the loader
interface ccff_loader_if;
    import fpga_cfg_pkg::*;
    logic [CFG_DATA_W-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;

    modport master (output s_data, s_valid, input s_ready);
    modport slave  (input s_data, s_valid, output s_ready);
endinterface

// File: rtl/ccff_byte_serializer.sv
// ccff_byte_serializer: byte buffer that feeds the chain MSB first with a registered head bit and clock-enable
module ccff_byte_serializer
    import fpga_cfg_pkg::*;
#(
    parameter int DATA_W    = CFG_DATA_W,
    parameter int NUM_BYTES = 1
) (
    input  logic         prog_clk,
    input  logic         pReset,
    input  logic         active,
    input  logic         restart,
    input  logic         shift_allow,
    input  logic         last_shift,
    ccff_loader_if.slave s_if,
    output logic         shift,
    output logic         head_bit,
    output logic         ccff_head,
    output logic         prog_clk_en
);
    localparam int CW = $clog2(DATA_W + 1);
    localparam int BW = $clog2(NUM_BYTES + 1);

    logic [DATA_W-1:0] data_buf_q, data_buf_d;
    logic [CW-1:0]     buf_cnt_q, buf_cnt_d;
    logic [BW-1:0]     byte_cnt_q, byte_cnt_d;
    logic              ccff_head_q, ccff_head_d;
    logic              prog_clk_en_q, prog_clk_en_d;
    logic              hs;

    // Refill the buffer when it empties (or is about to), shift one bit per enabled cycle, drop leftovers after the last bit
    always_comb begin
        shift         = active && buf_cnt_q != '0 && shift_allow;
        s_if.s_ready  = active && (buf_cnt_q == '0 || (buf_cnt_q == CW'(1) && shift))
                        && byte_cnt_q < BW'(NUM_BYTES);
        hs            = s_if.s_valid && s_if.s_ready;
        head_bit      = data_buf_q[DATA_W-1];
        data_buf_d    = hs ? DATA_W'(s_if.s_data) : shift ? data_buf_q << 1 : data_buf_q;
        buf_cnt_d     = restart ? '0 : hs ? CW'(DATA_W) : (shift && last_shift) ? '0 :
                        shift ? buf_cnt_q - 1'b1 : buf_cnt_q;
        byte_cnt_d    = restart ? '0 : hs ? byte_cnt_q + 1'b1 : byte_cnt_q;
        ccff_head_d   = shift ? head_bit : ccff_head_q;
        prog_clk_en_d = shift;
    end

    // Buffer, counters and the chain-facing outputs, cleared by the active-low synchronous reset
    always_ff @(posedge prog_clk) begin
        if (!pReset) begin
            data_buf_q    <= '0;
            buf_cnt_q     <= '0;
            byte_cnt_q    <= '0;
            ccff_head_q   <= 1'b0;
            prog_clk_en_q <= 1'b0;
        end else begin
            data_buf_q    <= data_buf_d;
            buf_cnt_q     <= buf_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            ccff_head_q   <= ccff_head_d;
            prog_clk_en_q <= prog_clk_en_d;
        end
    end

    assign ccff_head   = ccff_head_q;
    assign prog_clk_en = prog_clk_en_q;
endmodule

// File: rtl/ccff_loader.sv
// ccff_loader: load FSM that streams a bitstream into the configuration chain and checks the returned tail bit
module ccff_loader
    import fpga_cfg_pkg::*;
#(
    parameter int CHAIN_LEN = 6,
    parameter int DATA_W    = CFG_DATA_W
) (
    input  logic         prog_clk,
    input  logic         pReset,
    input  logic         start,
    ccff_loader_if.slave s_if,
    input  logic         ccff_tail,
    output logic         ccff_head,
    output logic         prog_clk_en,
    output logic         busy,
    output logic         done,
    output logic         cfg_error
);
    localparam int SW = $clog2(CHAIN_LEN + 1);
    localparam int NB = cfg_num_bytes(CHAIN_LEN);

    cfg_state_t    state_q, state_d;
    logic [SW-1:0] shift_cnt_q, shift_cnt_d;
    logic          first_bit_q, first_bit_d;
    logic          done_q, done_d;
    logic          cfg_error_q, cfg_error_d;
    logic          active, restart, shift_allow, last_shift, shift, head_bit;

    assign active      = state_q == ST_LOAD;
    assign restart     = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign shift_allow = shift_cnt_q < SW'(CHAIN_LEN);
    assign last_shift  = shift_cnt_q == SW'(CHAIN_LEN - 1);

    ccff_byte_serializer #(.DATA_W(DATA_W), .NUM_BYTES(NB)) u_ser (
        .prog_clk    (prog_clk),
        .pReset      (pReset),
        .active      (active),
        .restart     (restart),
        .shift_allow (shift_allow),
        .last_shift  (last_shift),
        .s_if        (s_if),
        .shift       (shift),
        .head_bit    (head_bit),
        .ccff_head   (ccff_head),
        .prog_clk_en (prog_clk_en)
    );

    // LOAD leaves one cycle after the final bit is registered so the chain has captured it before CHECK samples the tail
    always_comb begin
        state_d     = restart ? ST_LOAD : (active && !shift_allow) ? ST_CHECK :
                      state_q == ST_CHECK ? ST_DONE : state_q;
        shift_cnt_d = restart ? '0 : shift ? shift_cnt_q + 1'b1 : shift_cnt_q;
        first_bit_d = (shift && shift_cnt_q == '0) ? head_bit : first_bit_q;
        done_d      = restart ? 1'b0 : state_q == ST_CHECK ? 1'b1 : done_q;
        cfg_error_d = restart ? 1'b0 : state_q == ST_CHECK ? ccff_tail != first_bit_q : cfg_error_q;
    end

    // State register and status flops with active-low synchronous reset
    always_ff @(posedge prog_clk) begin
        if (!pReset) begin
            state_q     <= ST_IDLE;
            shift_cnt_q <= '0;
            first_bit_q <= 1'b0;
            done_q      <= 1'b0;
            cfg_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_cnt_q <= shift_cnt_d;
            first_bit_q <= first_bit_d;
            done_q      <= done_d;
            cfg_error_q <= cfg_error_d;
        end
    end

    assign busy      = state_q == ST_LOAD || state_q == ST_CHECK;
    assign done      = done_q;
    assign cfg_error = cfg_error_q;
endmodule

// File: tb/tb_ccff_loader.sv
// tb_ccff_loader: randomized loads into a 6-bit and a 20-bit chain checked against a bitstream-level model
module tb_ccff_loader;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] start, s_valid, stuck;
    logic [7:0] s_data [2];
    wire  [1:0] s_ready, head, en, busy, done, err, tail;
    logic [19:0] chain [2];
    int         n_vec = 0;
    int         n_bad = 0;
    string      pfx = "";

    ccff_loader_if if0 ();
    ccff_loader_if if1 ();

    assign if0.s_valid = s_valid[0];
    assign if0.s_data  = s_data[0];
    assign if1.s_valid = s_valid[1];
    assign if1.s_data  = s_data[1];
    assign s_ready     = {if1.s_ready, if0.s_ready};
    assign tail        = {stuck[1] ? 1'b0 : chain[1][19], stuck[0] ? 1'b0 : chain[0][5]};

    ccff_loader #(.CHAIN_LEN(6)) dut0 (
        .prog_clk(clk), .pReset(rst_n), .start(start[0]), .s_if(if0),
        .ccff_tail(tail[0]), .ccff_head(head[0]), .prog_clk_en(en[0]),
        .busy(busy[0]), .done(done[0]), .cfg_error(err[0])
    );

    ccff_loader #(.CHAIN_LEN(20)) dut1 (
        .prog_clk(clk), .pReset(rst_n), .start(start[1]), .s_if(if1),
        .ccff_tail(tail[1]), .ccff_head(head[1]), .prog_clk_en(en[1]),
        .busy(busy[1]), .done(done[1]), .cfg_error(err[1])
    );

    always #5 clk = ~clk;

    // Configuration chains: capture the head bit on every enabled edge
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++)
            if (en[k]) chain[k] <= {chain[k][18:0], head[k]};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s %s: got %0h expected %0h", pfx, tag, got, exp);
        end
    endtask

    task automatic run_load(input int k, input int gap, input bit stuck_v, input int ign_at,
                            input bit fixed, input logic [23:0] fb);
        int len = (k == 0) ? 6 : 20;
        int nb  = (len + 7) / 8;
        int bub = gap * (nb - 1);
        logic [7:0]  bytes [3];
        logic [31:0] exp_w = 0;
        logic [31:0] got_w = 0;
        int c = 0, bi = 0, wait_n = 0, n_en = 0, first_en = 0, last_en = 0, n_hs = 0, extra = 0;
        bit seen_done = 0;
        pfx = $sformatf("len%0d", len);
        for (int i = 0; i < 3; i++) bytes[i] = fixed ? fb[23 - 8*i -: 8] : 8'($urandom);
        if (stuck_v) bytes[0][7] = 1'b1;
        for (int i = 0; i < len; i++) exp_w = {exp_w[30:0], bytes[i/8][7 - i%8]};
        stuck[k] = stuck_v;
        @(negedge clk);
        start[k] = 1'b1;
        while (!seen_done && c < 120) begin
            @(negedge clk);
            c++;
            start[k] = (c == ign_at);
            if (c == 1) begin
                chk("c1_done", done[k], 0);
                chk("c1_err", err[k], 0);
                chk("c1_busy", busy[k], 1);
                chk("c1_ready", s_ready[k], 1);
                chk("c1_en", en[k], 0);
            end
            if (en[k]) begin
                n_en++;
                got_w = {got_w[30:0], head[k]};
                if (first_en == 0) first_en = c;
                last_en = c;
            end
            if (done[k]) seen_done = 1;
            else if (bi >= nb) begin
                s_valid[k] = 1'b1;
                s_data[k]  = 8'($urandom);
                if (s_ready[k]) extra++;
            end else if (s_ready[k] && wait_n > 0) begin
                wait_n--;
                s_valid[k] = 1'b0;
            end else begin
                s_valid[k] = 1'b1;
                s_data[k]  = bytes[bi];
                if (s_ready[k]) begin
                    bi++;
                    n_hs++;
                    wait_n = gap;
                end
            end
        end
        s_valid[k] = 1'b0;
        start[k]   = 1'b0;
        chk("done_seen", seen_done, 1);
        chk("done_cycle", c, len + 4 + bub);
        chk("first_en", first_en, 3);
        chk("en_count", n_en, len);
        chk("bubbles", last_en - first_en + 1 - n_en, bub);
        chk("handshakes", n_hs, nb);
        chk("extra_ready", extra, 0);
        chk("head_seq", got_w, exp_w);
        chk("chain", k == 0 ? 32'(chain[0][5:0]) : 32'(chain[1]), exp_w);
        chk("cfg_error", err[k], stuck_v ? 1 : 0);
        chk("busy_end", busy[k], 0);
    endtask

    task automatic mid_reset();
        int n = 0;
        pfx = "mid_rst";
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0]   = 1'b0;
        s_valid[0] = 1'b1;
        s_data[0]  = 8'($urandom);
        for (int c = 0; c < 20 && n < 3; c++) begin
            @(negedge clk);
            if (en[0]) n++;
        end
        chk("bits_before", n, 3);
        rst_n = 1'b0;
        @(negedge clk);
        chk("busy", busy[0], 0);
        chk("en", en[0], 0);
        chk("ready", s_ready[0], 0);
        rst_n      = 1'b1;
        s_valid[0] = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = '0;
        stuck   = '0;
        s_valid = 2'b11;
        s_data  = '{8'hFF, 8'hFF};
        pfx     = "reset";
        repeat (2) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++)
                chk($sformatf("outs%0d", k), {s_ready[k], head[k], en[k], busy[k], done[k], err[k]}, 0);
        end
        rst_n   = 1'b1;
        s_valid = '0;
        run_load(0, 0, 0, 0, 1, 24'hB40000);
        repeat (3) run_load(0, 0, 0, 0, 0, 24'h0);
        run_load(1, 2, 0, 0, 1, 24'hFF00A5);
        repeat (2) run_load(1, int'($urandom_range(0, 3)), 0, 0, 0, 24'h0);
        run_load(0, 0, 1, 0, 0, 24'h0);
        run_load(1, 1, 1, 0, 0, 24'h0);
        run_load(1, 0, 0, 6, 0, 24'h0);
        run_load(0, 0, 0, 4, 0, 24'h0);
        mid_reset();
        run_load(0, 0, 0, 0, 0, 24'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
